// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmit-sink signal bundle for uart_tx_arbiter.
// The arbiter takes the slave side; requesters and the sink take the master side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   i_req_valid;
    logic [8*NREQ-1:0] i_req_data;
    logic [NREQ-1:0]   i_req_last;
    logic [NREQ-1:0]   o_req_ready;
    logic [NREQ-1:0]   o_grant;
    logic [7:0]        o_tx_byte;
    logic              o_tx_stb;
    logic              i_tx_busy;
    logic              o_busy;
    logic              o_timeout;

    modport master (
        output i_req_valid,
        output i_req_data,
        output i_req_last,
        output i_tx_busy,
        input  o_req_ready,
        input  o_grant,
        input  o_tx_byte,
        input  o_tx_stb,
        input  o_busy,
        input  o_timeout
    );

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        input  i_req_last,
        input  i_tx_busy,
        output o_req_ready,
        output o_grant,
        output o_tx_byte,
        output o_tx_stb,
        output o_busy,
        output o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmit path
// between NREQ packet requesters, with a mid-packet stall watchdog.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            stb_q, stb_d;
    logic            to_q, to_d;

    logic            own_valid;
    logic            own_last;
    logic [7:0]      own_data;
    logic [TW-1:0]   cnt_inc;

    logic [2*NREQ-1:0] vld_dbl;
    logic [2*NREQ-1:0] oh_dbl;
    logic [NREQ-1:0]   vld_rot;
    logic [NREQ-1:0]   oh_rot;
    logic [NREQ-1:0]   sel_onehot;
    logic [PW-1:0]     sel_next;
    logic              sel_found;

    // Owner's request lines, picked out by the one-hot grant.
    always_comb begin
        own_valid = |(grant_q & bus.i_req_valid);
        own_last  = |(grant_q & bus.i_req_last);
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            own_data = own_data | (bus.i_req_data[8*i +: 8] & {8{grant_q[i]}});
        end
    end

    // First valid requester at or after ptr, found in a rotated view.
    always_comb begin
        vld_dbl   = {bus.i_req_valid, bus.i_req_valid} >> ptr_q;
        vld_rot   = vld_dbl[NREQ-1:0];
        oh_rot    = '0;
        sel_found = 1'b0;
        sel_next  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_found && vld_rot[k]) begin
                sel_found = 1'b1;
                oh_rot[k] = 1'b1;
                sel_next  = PW'((int'(ptr_q) + k + 1) % NREQ);
            end
        end
        oh_dbl     = {oh_rot, oh_rot} << ptr_q;
        sel_onehot = oh_dbl[2*NREQ-1:NREQ];
    end

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state logic: selection, byte forwarding and watchdog.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        stb_d   = 1'b0;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_onehot;
                    ptr_d   = sel_next;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (own_valid && !bus.i_tx_busy) begin
                    byte_d = own_data;
                    stb_d  = 1'b1;
                    cnt_d  = '0;
                    if (own_last) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (!own_valid) begin
                    if (cnt_inc == TW'(TIMEOUT)) begin
                        grant_d = '0;
                        to_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            HOLD: begin
                // Strobe cycle: sink busy is not valid until next cycle.
                state_d = GRANT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            stb_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            stb_q   <= stb_d;
            to_q    <= to_d;
        end
    end

    assign bus.o_req_ready = (state_q == GRANT && !bus.i_tx_busy)
                           ? (grant_q & bus.i_req_valid) : '0;
    assign bus.o_grant     = grant_q;
    assign bus.o_tx_byte   = byte_q;
    assign bus.o_tx_stb    = stb_q;
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_timeout   = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized
// packet traffic compared against a packet-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam int TW      = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .TIMEOUT(TIMEOUT),
        .TW(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0] mem [NREQ][256];
    int wr [NREQ];
    int rd [NREQ];
    int gap [NREQ];
    bit stall [NREQ];
    int gapmax = 0;
    int blen = 1;
    bit busy_force = 0;
    int sink_cnt = 0;

    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] rdy_seen;
    logic [NREQ-1:0] gseen;
    logic [7:0] sent [$];
    int own_log [$];
    int nto;

    int npk [NREQ];
    int plen [NREQ][8];
    logic [7:0] exp_b [$];
    int exp_o [$];
    int n;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bit v;
            v = (rd[i] < wr[i]) && (gap[i] == 0) && !stall[i];
            bus.i_req_valid[i] = v;
            if (v) begin
                bus.i_req_data[8*i +: 8] = mem[i][rd[i]][7:0];
                bus.i_req_last[i]        = mem[i][rd[i]][8];
            end else begin
                bus.i_req_data[8*i +: 8] = 8'($urandom);
                bus.i_req_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic push_byte(int r, logic [7:0] b, logic l);
        mem[r][wr[r]] = {l, b};
        wr[r]++;
    endtask

    // One clock: sample handshake at negedge, update models after posedge.
    task automatic tick();
        @(negedge clk);
        acc = bus.i_req_valid & bus.o_req_ready;
        rdy_seen = rdy_seen | bus.o_req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) own_log.push_back(i);
        end
        @(posedge clk);
        #1;
        chk("grant_onehot0", 32'($onehot0(bus.o_grant)), 32'd1);
        gseen = gseen | bus.o_grant;
        if (bus.o_tx_stb) sent.push_back(bus.o_tx_byte);
        if (bus.o_timeout) nto++;
        for (int i = 0; i < NREQ; i++) begin
            if (gap[i] > 0) gap[i]--;
            if (acc[i]) begin
                if (!mem[i][rd[i]][8] && gapmax > 0)
                    gap[i] = $urandom_range(gapmax, 0);
                rd[i]++;
            end
        end
        bus.i_tx_busy = busy_force || (sink_cnt > 0);
        if (sink_cnt > 0) sink_cnt--;
        if (bus.o_tx_stb)
            sink_cnt = (blen > 0) ? blen : $urandom_range(4, 1);
        drive();
    endtask

    function automatic bit all_idle();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (rd[i] < wr[i] && !stall[i]) e = 1'b0;
        end
        return e && !bus.o_busy && !bus.o_tx_stb
            && sink_cnt == 0 && !bus.i_tx_busy;
    endfunction

    task automatic wait_done(int budget, string tag);
        int k;
        k = 0;
        while (k < budget && !all_idle()) begin
            tick();
            k++;
        end
        chk({tag, "_drain"}, 32'(k < budget), 32'd1);
    endtask

    task automatic clear_logs();
        sent.delete();
        own_log.delete();
        nto = 0;
        rdy_seen = '0;
        gseen = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rd[i] = 0;
            wr[i] = 0;
            gap[i] = 0;
            stall[i] = 1'b0;
        end
        sink_cnt = 0;
        busy_force = 1'b0;
        bus.i_tx_busy = 1'b0;
        drive();
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    // Packet-level reference: serve whole packets round-robin from ptr.
    task automatic build_expect();
        int ptr;
        int left;
        int nxt [NREQ];
        int pos [NREQ];
        ptr = 0;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
            nxt[i] = 0;
            pos[i] = 0;
            left += npk[i];
        end
        exp_b.delete();
        exp_o.delete();
        while (left > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int r;
                r = (ptr + k) % NREQ;
                if (nxt[r] < npk[r]) begin
                    for (int j = 0; j < plen[r][nxt[r]]; j++) begin
                        exp_b.push_back(mem[r][pos[r]][7:0]);
                        exp_o.push_back(r);
                        pos[r]++;
                    end
                    nxt[r]++;
                    left--;
                    ptr = (r + 1) % NREQ;
                    break;
                end
            end
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_grant", 32'(bus.o_grant), 32'h0);
        chk("rst_stb", 32'(bus.o_tx_stb), 32'h0);
        chk("rst_byte", 32'(bus.o_tx_byte), 32'h0);
        chk("rst_timeout", 32'(bus.o_timeout), 32'h0);
        chk("rst_ready", 32'(bus.o_req_ready), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);

        // Single requester, 3-byte packet, latency 2
        blen = 4;
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b1);
        drive();
        tick();
        chk("t1_grant_t1", 32'(bus.o_grant), 32'h1);
        chk("t1_stb_t1", 32'(bus.o_tx_stb), 32'h0);
        tick();
        chk("t1_stb_t2", 32'(bus.o_tx_stb), 32'h1);
        chk("t1_byte_t2", 32'(bus.o_tx_byte), 32'h41);
        wait_done(200, "t1");
        chk("t1_count", 32'(sent.size()), 32'd3);
        for (int i = 0; i < 3 && i < sent.size(); i++)
            chk("t1_byte", 32'(sent[i]), 32'h41 + 32'(i));
        chk("t1_gseen", 32'(gseen), 32'h1);
        chk("t1_grant_end", 32'(bus.o_grant), 32'h0);

        // Round-robin fairness, two rounds
        do_reset();
        blen = 2;
        for (int rnd = 0; rnd < 2; rnd++) begin
            own_log.delete();
            for (int i = 0; i < NREQ; i++)
                push_byte(i, 8'(16 * i + rnd), 1'b1);
            drive();
            wait_done(200, "t2");
            chk("t2_count", 32'(own_log.size()), 32'd4);
            for (int i = 0; i < 4 && i < own_log.size(); i++)
                chk("t2_order", 32'(own_log[i]), 32'(i));
        end

        // Packet lock, then ptr order 2,3,0
        do_reset();
        blen = 0;
        for (int i = 0; i < 4; i++)
            push_byte(1, 8'(8'h10 + i), i == 3);
        drive();
        n = 0;
        while (n < 100 && own_log.size() < 2) begin
            tick();
            n++;
        end
        push_byte(0, 8'h01, 1'b1);
        push_byte(2, 8'h21, 1'b1);
        push_byte(3, 8'h31, 1'b1);
        drive();
        wait_done(400, "t3");
        begin
            int eo [7];
            eo = '{1, 1, 1, 1, 2, 3, 0};
            chk("t3_count", 32'(own_log.size()), 32'd7);
            for (int i = 0; i < 7 && i < own_log.size(); i++)
                chk("t3_order", 32'(own_log[i]), 32'(eo[i]));
        end

        // Sink back-pressure never times out
        do_reset();
        blen = 2;
        busy_force = 1'b1;
        bus.i_tx_busy = 1'b1;
        push_byte(1, 8'h5A, 1'b1);
        drive();
        repeat (2000) tick();
        chk("t4_grant", 32'(bus.o_grant), 32'h2);
        chk("t4_no_stb", 32'(sent.size()), 32'd0);
        chk("t4_no_to", 32'(nto), 32'd0);
        chk("t4_no_ready", 32'(rdy_seen), 32'h0);
        busy_force = 1'b0;
        bus.i_tx_busy = 1'b0;
        tick();
        chk("t4_stb", 32'(bus.o_tx_stb), 32'h1);
        chk("t4_byte", 32'(bus.o_tx_byte), 32'h5A);
        wait_done(50, "t4");

        // Watchdog revokes a stalled owner
        do_reset();
        blen = 3;
        push_byte(2, 8'hA0, 1'b0);
        push_byte(2, 8'hA1, 1'b1);
        push_byte(3, 8'hB0, 1'b1);
        drive();
        n = 0;
        while (n < 50 && own_log.size() < 1) begin
            tick();
            n++;
        end
        stall[2] = 1'b1;
        drive();
        n = 0;
        while (n < 40 && !bus.o_timeout) begin
            tick();
            n++;
        end
        chk("t5_wd_cycles", 32'(n), 32'd16);
        chk("t5_grant_rel", 32'(bus.o_grant), 32'h0);
        chk("t5_busy_rel", 32'(bus.o_busy), 32'h0);
        tick();
        chk("t5_to_once", 32'(bus.o_timeout), 32'h0);
        chk("t5_next_grant", 32'(bus.o_grant), 32'h8);
        rd[2] = wr[2];
        stall[2] = 1'b0;
        drive();
        wait_done(100, "t5");
        chk("t5_nto", 32'(nto), 32'd1);
        chk("t5_count", 32'(sent.size()), 32'd2);
        if (sent.size() == 2) begin
            chk("t5_b0", 32'(sent[0]), 32'hA0);
            chk("t5_b1", 32'(sent[1]), 32'hB0);
        end

        // Reset during HOLD
        do_reset();
        blen = 2;
        push_byte(1, 8'h10, 1'b0);
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h12, 1'b1);
        drive();
        n = 0;
        while (n < 50 && own_log.size() < 1) begin
            tick();
            n++;
        end
        chk("t6_pre_stb", 32'(bus.o_tx_stb), 32'h1);
        rst = 1'b1;
        tick();
        chk("t6_stb", 32'(bus.o_tx_stb), 32'h0);
        chk("t6_grant", 32'(bus.o_grant), 32'h0);
        chk("t6_busy", 32'(bus.o_busy), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rd[i] = wr[i];
            gap[i] = 0;
        end
        sink_cnt = 0;
        bus.i_tx_busy = 1'b0;
        clear_logs();
        push_byte(1, 8'h15, 1'b1);
        push_byte(3, 8'h35, 1'b1);
        drive();
        wait_done(100, "t6");
        chk("t6_count", 32'(own_log.size()), 32'd2);
        if (own_log.size() == 2) begin
            chk("t6_first", 32'(own_log[0]), 32'd1);
            chk("t6_second", 32'(own_log[1]), 32'd3);
        end

        // Randomized traffic against the packet-level model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            gapmax = 5;
            blen = 0;
            for (int i = 0; i < NREQ; i++) begin
                npk[i] = $urandom_range(4, 1);
                for (int k = 0; k < npk[i]; k++) begin
                    plen[i][k] = $urandom_range(5, 1);
                    for (int j = 0; j < plen[i][k]; j++)
                        push_byte(i, 8'($urandom), j == plen[i][k] - 1);
                end
            end
            build_expect();
            drive();
            wait_done(6000, "rnd");
            chk("rnd_count", 32'(sent.size()), 32'(exp_b.size()));
            chk("rnd_acc", 32'(own_log.size()), 32'(exp_o.size()));
            for (int i = 0; i < exp_b.size() && i < sent.size(); i++)
                chk("rnd_byte", 32'(sent[i]), 32'(exp_b[i]));
            for (int i = 0; i < exp_o.size() && i < own_log.size(); i++)
                chk("rnd_owner", 32'(own_log[i]), 32'(exp_o[i]));
            chk("rnd_no_to", 32'(nto), 32'd0);
            gapmax = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single byte-wide UART transmit path between NREQ independent requesters (board dump, score reporter, debug monitor, etc.).
- Each requester sends variable-length packets of bytes. The arbiter grants one requester at a time, round-robin, and holds the grant until that packet completes.
- It forwards each byte to the transmit sink through a strobe/busy handshake.
- A watchdog releases the grant if the owner stalls mid-packet.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, idle cycles allowed mid-packet before the grant is revoked (>=1).
- TW, 10, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- i_req_valid  input  NREQ  per-requester byte valid.
- i_req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- i_req_last  input  NREQ  marks the final byte of the packet; qualified by valid.
- o_req_ready  output  NREQ  accept pulse: requester i's byte is taken in any cycle where valid[i]&ready[i].
- o_grant  output  NREQ  one-hot current owner; zero when idle.
- o_tx_byte  output  8  byte to the transmit sink.
- o_tx_stb  output  1  one-cycle transmit strobe.
- i_tx_busy  input  1  sink busy. Goes high the cycle after o_tx_stb and stays high until the sink can take a new byte.
- o_busy  output  1  high whenever state != IDLE.
- o_timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset values: state=IDLE, o_grant=0, o_tx_byte=0, o_tx_stb=0, o_timeout=0, o_req_ready=0, rr pointer=0, timeout counter=0.
- States: IDLE, GRANT, HOLD.
- IDLE, selection: if any valid, select the first index i with valid[i], searching from ptr upward modulo NREQ.
  - Register o_grant=onehot(i) and ptr=(i+1)%NREQ, then go to GRANT.
  - With no valid, stay in IDLE.
- GRANT, accept condition: with owner g, the byte is accepted when valid[g] & ~i_tx_busy.
  - o_req_ready[g] is combinational: (state==GRANT) & o_grant[g] & ~i_tx_busy & valid[g].
  - All other ready bits are 0.
- GRANT, on accept: next cycle o_tx_byte=data[g] and o_tx_stb=1; the timeout counter clears.
  - If last[g]=1: o_grant clears and the next state is IDLE.
  - Otherwise the next state is HOLD.
- HOLD: lasts exactly 1 cycle (the strobe cycle), so that the registered busy is seen. Then back to GRANT.
  - IDLE also spans the strobe cycle after a last byte. Either way, GRANT never samples busy in the strobe cycle.
- GRANT, owner not valid: if valid[g]=0, the counter increments.
  - When the counter reaches TIMEOUT: o_grant clears, o_timeout pulses next cycle, the counter clears, and the next state is IDLE.
  - ptr is already past g, so other requesters get service first.
- GRANT, valid but sink busy: if valid[g]=1 and i_tx_busy=1, the counter holds. Sink back-pressure never times out.
- Throughput: minimum 2 cycles per byte. Latency from valid (idle arbiter, idle sink) to o_tx_stb is 2 cycles: grant at t+1, strobe at t+2.
- o_tx_byte holds its last value between strobes.
- Simultaneous requests: lowest index at or after ptr wins.
- Mid-packet changes by other requesters are ignored until the owner releases the grant.
- A requester dropping valid after last is allowed.
- A single-byte packet (last on first byte) releases the grant after one strobe.
- Reset mid-packet: immediate return to reset values. Any in-flight strobe is dropped; no partial-packet recovery.

Test Plan:
- Single requester: req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), sink busy for 4 cycles after each stb → exactly 3 stb pulses in order, o_grant=0001 throughout, then 0.
- Round-robin fairness: all 4 requesters present 1-byte packets simultaneously from reset → grant order 0,1,2,3; each then re-requests → order 0,1,2,3 again.
- Packet lock: req1 owns a 4-byte packet; req0 asserts valid during byte 2 → no req0 byte is sent until after req1's last byte; then req2/req3 are checked before req0 per ptr.
- Back-pressure: i_tx_busy held high 2000 cycles while the owner is valid → no stb, no timeout, ready stays 0; busy drops → byte sent within 1 cycle.
- Watchdog: TIMEOUT=15, req2 sends 1 non-last byte then drops valid → o_timeout pulses after 15 idle cycles in GRANT, o_grant=0; a waiting req3 is granted next.
- Reset mid-packet: rst asserted during HOLD → next cycle o_tx_stb=0, o_grant=0, o_busy=0; the first post-reset request is granted from ptr=0.
